// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default widths and strobe-width derivation.
// Used by both the requester and the completer side of the accelerator bus.
package apb_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StSetup  = 2'b01,
      StAccess = 2'b10
   } apb_state_e;

   localparam int unsigned DefDataWidth = 32;
   localparam int unsigned DefBusWidth  = 64;
   localparam int unsigned DefAddrWidth = 32;

   // One strobe bit per DATA_WIDTH lane of the bus.
   function automatic int unsigned max_dim(input int unsigned bus_w, input int unsigned data_w);
      return bus_w / data_w;
   endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS wait cycles and flags the cycle whose increment would reach TIMEOUT_CYCLES.
// TIMEOUT_CYCLES = 0 disables the flag entirely.
module apb_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CntW-1:0] count_q;

   // Combinational so the FSM can leave ACCESS on the same edge the count would hit the limit.
   assign expired_o = (TIMEOUT_CYCLES != 0) && en_i &&
                      (count_q == CntW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (en_i && !expired_o) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/apb_master_module.sv
// APB requester: converts single host commands into SETUP/ACCESS transfers and returns
// read data plus error status (completer error or wait-state timeout) per command.
module apb_master_module
   import apb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DefDataWidth,
   parameter int unsigned BUS_WIDTH      = DefBusWidth,
   parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   localparam int unsigned MAX_DIM       = max_dim(BUS_WIDTH, DATA_WIDTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [BUS_WIDTH-1:0]  req_wdata_i,
   input  logic [MAX_DIM-1:0]    req_strb_i,
   output logic                  rsp_valid_o,
   output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  busy_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [BUS_WIDTH-1:0]  pwdata_o,
   output logic [MAX_DIM-1:0]    pstrb_o,
   input  logic                  pready_i,
   input  logic                  pslverr_i,
   input  logic [BUS_WIDTH-1:0]  prdata_i
);

   apb_state_e            state_q;
   logic                  req_ready_q;
   logic                  rsp_valid_q;
   logic [BUS_WIDTH-1:0]  rsp_rdata_q;
   logic                  rsp_err_q;
   logic                  busy_q;
   logic                  psel_q;
   logic                  penable_q;
   logic                  pwrite_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic [BUS_WIDTH-1:0]  pwdata_q;
   logic [MAX_DIM-1:0]    pstrb_q;

   logic accept;
   logic wait_cycle;
   logic expired;

   assign accept     = (state_q == StIdle) && req_valid_i;
   assign wait_cycle = (state_q == StAccess) && !pready_i;

   apb_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (accept),
      .en_i      (wait_cycle),
      .expired_o (expired)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  state_q     <= StSetup;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  psel_q      <= 1'b1;
                  pwrite_q    <= req_write_i;
                  paddr_q     <= req_addr_i;
                  // Reads never present write data or strobes on the bus.
                  pwdata_q    <= req_write_i ? req_wdata_i : '0;
                  pstrb_q     <= req_write_i ? req_strb_i : '0;
               end
            end
            StSetup: begin
               state_q   <= StAccess;
               penable_q <= 1'b1;
            end
            StAccess: begin
               if (pready_i || expired) begin
                  state_q     <= StIdle;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  pwrite_q    <= 1'b0;
                  paddr_q     <= '0;
                  pwdata_q    <= '0;
                  pstrb_q     <= '0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= pready_i ? pslverr_i : 1'b1;
                  rsp_rdata_q <= (pready_i && !pwrite_q && !pslverr_i) ? prdata_i : '0;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign busy_o      = busy_q;
   assign psel_o      = psel_q;
   assign penable_o   = penable_q;
   assign pwrite_o    = pwrite_q;
   assign paddr_o     = paddr_q;
   assign pwdata_o    = pwdata_q;
   assign pstrb_o     = pstrb_q;

endmodule

// File: tb/tb_apb_master_module.sv
// Directed bench for apb_master_module: write, waited read, slave error, timeout,
// mid-transfer reset and back-to-back acceptance with req_valid held high.
module tb_apb_master_module;

   logic        clk_i;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_write_i;
   logic [31:0] req_addr_i;
   logic [63:0] req_wdata_i;
   logic [1:0]  req_strb_i;
   logic        rsp_valid_o;
   logic [63:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        busy_o;
   logic        psel_o;
   logic        penable_o;
   logic        pwrite_o;
   logic [31:0] paddr_o;
   logic [63:0] pwdata_o;
   logic [1:0]  pstrb_o;
   logic        pready_i;
   logic        pslverr_i;
   logic [63:0] prdata_i;

   int checks = 0;
   int errors = 0;

   apb_master_module #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_write_i (req_write_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .req_strb_i  (req_strb_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .busy_o      (busy_o),
      .psel_o      (psel_o),
      .penable_o   (penable_o),
      .pwrite_o    (pwrite_o),
      .paddr_o     (paddr_o),
      .pwdata_o    (pwdata_o),
      .pstrb_o     (pstrb_o),
      .pready_i    (pready_i),
      .pslverr_i   (pslverr_i),
      .prdata_i    (prdata_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_ni      = 1'b0;
      req_valid_i = 1'b0;
      req_write_i = 1'b0;
      req_addr_i  = '0;
      req_wdata_i = '0;
      req_strb_i  = '0;
      pready_i    = 1'b1;
      pslverr_i   = 1'b0;
      prdata_i    = '0;
      tick();
      tick();
      chk("rst_ready", req_ready_o, 1);
      chk("rst_psel", psel_o, 0);
      chk("rst_penable", penable_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      rst_ni = 1'b1;
      tick();

      // 1: write, no wait states
      req_valid_i = 1'b1;
      req_write_i = 1'b1;
      req_addr_i  = 32'h1;
      req_wdata_i = 64'hDEADBEEF_12345678;
      req_strb_i  = 2'b11;
      pready_i    = 1'b1;
      tick();
      req_valid_i = 1'b0;
      chk("w_setup_psel", psel_o, 1);
      chk("w_setup_penable", penable_o, 0);
      chk("w_setup_ready", req_ready_o, 0);
      chk("w_setup_busy", busy_o, 1);
      chk("w_setup_pwrite", pwrite_o, 1);
      chk("w_setup_paddr", paddr_o, 64'h1);
      chk("w_setup_pwdata", pwdata_o, 64'hDEADBEEF_12345678);
      chk("w_setup_pstrb", pstrb_o, 2'b11);
      tick();
      chk("w_access_penable", penable_o, 1);
      chk("w_access_psel", psel_o, 1);
      chk("w_access_pstrb", pstrb_o, 2'b11);
      chk("w_access_rsp_valid", rsp_valid_o, 0);
      tick();
      chk("w_rsp_valid", rsp_valid_o, 1);
      chk("w_rsp_err", rsp_err_o, 0);
      chk("w_rsp_rdata", rsp_rdata_o, 0);
      chk("w_done_psel", psel_o, 0);
      chk("w_done_ready", req_ready_o, 1);
      chk("w_done_busy", busy_o, 0);
      tick();
      chk("w_rsp_pulse", rsp_valid_o, 0);

      // 2: read, two wait states; write data/strobe inputs must not leak onto the bus
      req_valid_i = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = 32'h10;
      req_wdata_i = 64'h1111_2222_3333_4444;
      req_strb_i  = 2'b11;
      pready_i    = 1'b0;
      prdata_i    = 64'hA5A5A5A5_5A5A5A5A;
      tick();
      req_valid_i = 1'b0;
      chk("r_setup_pstrb", pstrb_o, 0);
      chk("r_setup_pwdata", pwdata_o, 0);
      chk("r_setup_pwrite", pwrite_o, 0);
      chk("r_setup_paddr", paddr_o, 64'h10);
      tick();
      chk("r_access1_penable", penable_o, 1);
      tick();
      chk("r_access2_penable", penable_o, 1);
      chk("r_wait1_rsp_valid", rsp_valid_o, 0);
      tick();
      chk("r_access3_penable", penable_o, 1);
      chk("r_wait2_pstrb", pstrb_o, 0);
      pready_i = 1'b1;
      tick();
      chk("r_rsp_valid", rsp_valid_o, 1);
      chk("r_rsp_rdata", rsp_rdata_o, 64'hA5A5A5A5_5A5A5A5A);
      chk("r_rsp_err", rsp_err_o, 0);
      chk("r_done_penable", penable_o, 0);
      tick();
      chk("r_rdata_hold", rsp_rdata_o, 64'hA5A5A5A5_5A5A5A5A);

      // 3: read with completer error
      req_valid_i = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = 32'h20;
      pready_i    = 1'b1;
      pslverr_i   = 1'b1;
      prdata_i    = 64'h0123_4567_89AB_CDEF;
      tick();
      req_valid_i = 1'b0;
      tick();
      tick();
      chk("e_rsp_valid", rsp_valid_o, 1);
      chk("e_rsp_err", rsp_err_o, 1);
      chk("e_rsp_rdata", rsp_rdata_o, 0);
      pslverr_i = 1'b0;
      tick();

      // 4: timeout after 4 ACCESS cycles with pready stuck low
      req_valid_i = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = 32'h30;
      pready_i    = 1'b0;
      prdata_i    = 64'hFFFF_0000_FFFF_0000;
      tick();
      req_valid_i = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk("t_access4_penable", penable_o, 1);
      chk("t_access4_rsp_valid", rsp_valid_o, 0);
      tick();
      chk("t_rsp_valid", rsp_valid_o, 1);
      chk("t_rsp_err", rsp_err_o, 1);
      chk("t_rsp_rdata", rsp_rdata_o, 0);
      chk("t_psel", psel_o, 0);
      chk("t_penable", penable_o, 0);
      tick();

      // 5: reset during ACCESS
      req_valid_i = 1'b1;
      req_write_i = 1'b1;
      req_addr_i  = 32'h40;
      req_wdata_i = 64'hCAFE;
      req_strb_i  = 2'b01;
      pready_i    = 1'b0;
      tick();
      req_valid_i = 1'b0;
      tick();
      chk("x_in_access", penable_o, 1);
      rst_ni = 1'b0;
      #2;
      chk("x_rst_ready", req_ready_o, 1);
      chk("x_rst_psel", psel_o, 0);
      chk("x_rst_penable", penable_o, 0);
      chk("x_rst_busy", busy_o, 0);
      chk("x_rst_paddr", paddr_o, 0);
      chk("x_rst_pwdata", pwdata_o, 0);
      chk("x_rst_pstrb", pstrb_o, 0);
      chk("x_rst_err", rsp_err_o, 0);
      chk("x_rst_rsp_valid", rsp_valid_o, 0);
      tick();
      rst_ni   = 1'b1;
      pready_i = 1'b1;
      tick();
      chk("x_post_rsp_valid", rsp_valid_o, 0);
      req_valid_i = 1'b1;
      req_write_i = 1'b1;
      req_addr_i  = 32'h44;
      req_wdata_i = 64'hBEEF;
      req_strb_i  = 2'b10;
      tick();
      req_valid_i = 1'b0;
      chk("x_next_pstrb", pstrb_o, 2'b10);
      tick();
      tick();
      chk("x_next_rsp_valid", rsp_valid_o, 1);
      chk("x_next_rsp_err", rsp_err_o, 0);
      tick();

      // 6: req_valid held high; second command accepted only in the response cycle
      req_valid_i = 1'b1;
      req_write_i = 1'b1;
      req_addr_i  = 32'hA0;
      req_wdata_i = 64'h55;
      req_strb_i  = 2'b11;
      pready_i    = 1'b1;
      tick();
      req_addr_i  = 32'hB0;
      req_wdata_i = 64'h66;
      chk("h_first_ready", req_ready_o, 0);
      chk("h_first_paddr", paddr_o, 64'hA0);
      tick();
      chk("h_hold_paddr", paddr_o, 64'hA0);
      chk("h_hold_pwdata", pwdata_o, 64'h55);
      tick();
      chk("h_rsp_valid", rsp_valid_o, 1);
      chk("h_rsp_ready", req_ready_o, 1);
      tick();
      req_valid_i = 1'b0;
      chk("h_second_psel", psel_o, 1);
      chk("h_second_paddr", paddr_o, 64'hB0);
      chk("h_second_rsp_valid", rsp_valid_o, 0);
      tick();
      tick();
      chk("h_second_rsp", rsp_valid_o, 1);
      tick();
      chk("h_idle_ready", req_ready_o, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
